sr_bank_ctrl: RTL and testbench

Sequencer and arbiter for a bank of N NAND-style master-slave SR flip-flops with active-low S/R inputs. Two requesters issue set/clear writes to individual flip-flops. The block arbitrates round-robin and drives one clean active-low pulse on the selected S_n or R_n line, never producing the forbidden S=R=0 combination. It then reads back Q to confirm the write and retries on mismatch. It sits between the lab's control logic and the flip-flop bank, replacing hand-driven S/R stimulus.

---
 rtl/sr_bank_pkg.sv | 24 ++
 rtl/sr_bank_ctrl_rr_arb2.sv | 34 +++
 rtl/sr_bank_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sr_bank_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared types for the SR flip-flop bank sequencer.
// Readback/retry is built only when SRBANK_VERIFY_EN is defined.
package sr_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_RECOVER,
        ST_CHECK
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    localparam int RETRY_W = 2;

    function automatic logic idx_ok(input int unsigned idx,
                                    input int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/sr_bank_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the last-grant register moves only
// when a grant is actually taken (en high in IDLE).
module rr_arb2
    import sr_bank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic a_req,
    input  logic b_req,
    output logic gnt_a,
    output logic gnt_b
);

    req_e last_q, last_d;

    always_comb begin
        gnt_a  = en & a_req & (~b_req | (last_q == REQ_B));
        gnt_b  = en & b_req & (~a_req | (last_q == REQ_A));
        last_d = last_q;
        if (gnt_a)
            last_d = REQ_A;
        else if (gnt_b)
            last_d = REQ_B;
    end

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= REQ_B;
        else
            last_q <= last_d;
    end

endmodule

// File: rtl/sr_bank_ctrl.sv
// Arbitrated set/clear sequencer for a bank of active-low SR flip-flops.
// SRBANK_VERIFY_EN adds Q readback with bounded retries.
module sr_bank_ctrl
    import sr_bank_pkg::*;
#(
    parameter int N         = 8,
    parameter int IDX_W     = (N > 1) ? $clog2(N) : 1,
    parameter int PULSE_CYC = 2,
    parameter int MAX_RETRY = 3,
    parameter int RW        = RETRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [IDX_W-1:0] a_idx,
    input  logic             a_val,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [IDX_W-1:0] b_idx,
    input  logic             b_val,
    output logic             b_ready,
    output logic [N-1:0]     S_n,
    output logic [N-1:0]     R_n,
    input  logic [N-1:0]     Q,
    output logic             busy,
    output logic             err,
    output logic [IDX_W-1:0] err_idx,
    input  logic             err_clr
);

    localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             val_q, val_d;
    logic             bad_q, bad_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [N-1:0]     s_n_q, s_n_d;
    logic [N-1:0]     r_n_q, r_n_d;
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             gnt_a, gnt_b;
    logic [IDX_W-1:0] req_idx;
    logic             req_val;

`ifdef SRBANK_VERIFY_EN
    logic [RW-1:0]    retry_q, retry_d;
`else
    logic             unused_ok;
    assign unused_ok = ^{Q, RW'(MAX_RETRY)};
`endif

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == ST_IDLE),
        .a_req (a_valid),
        .b_req (b_valid),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b)
    );

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign req_idx = gnt_a ? a_idx : b_idx;
    assign req_val = gnt_a ? a_val : b_val;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        val_d     = val_q;
        bad_d     = bad_q;
        pcnt_d    = pcnt_q;
        err_d     = err_q & ~err_clr;
        err_idx_d = err_idx_q;
        s_n_d     = '1;
        r_n_d     = '1;
`ifdef SRBANK_VERIFY_EN
        retry_d   = retry_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_a | gnt_b) begin
                    idx_d  = req_idx;
                    val_d  = req_val;
                    pcnt_d = '0;
                    bad_d  = ~idx_ok(32'(req_idx), N);
`ifdef SRBANK_VERIFY_EN
                    retry_d = '0;
`endif
                    // Out-of-range target: flag it and idle one cycle.
                    if (bad_d) begin
                        err_d     = 1'b1;
                        err_idx_d = req_idx;
                        state_d   = ST_RECOVER;
                    end else begin
                        state_d   = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                if (pcnt_q == PW'(PULSE_CYC - 1)) begin
                    pcnt_d  = '0;
                    state_d = ST_RECOVER;
                end else begin
                    pcnt_d  = pcnt_q + 1'b1;
                end
            end
            ST_RECOVER: begin
`ifdef SRBANK_VERIFY_EN
                state_d = bad_q ? ST_IDLE : ST_CHECK;
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
`ifdef SRBANK_VERIFY_EN
                if (Q[idx_q] != val_q) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_DRIVE;
                    end else begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                    end
                end
`endif
            end
        endcase
        // Lines are registered alongside the state they belong to.
        if (state_d == ST_DRIVE && !bad_d) begin
            if (val_d)
                s_n_d[idx_d] = 1'b0;
            else
                r_n_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            val_q     <= 1'b0;
            bad_q     <= 1'b0;
            pcnt_q    <= '0;
            s_n_q     <= '1;
            r_n_q     <= '1;
            err_q     <= 1'b0;
            err_idx_q <= '0;
`ifdef SRBANK_VERIFY_EN
            retry_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            bad_q     <= bad_d;
            pcnt_q    <= pcnt_d;
            s_n_q     <= s_n_d;
            r_n_q     <= r_n_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
`ifdef SRBANK_VERIFY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign S_n     = s_n_q;
    assign R_n     = r_n_q;
    assign busy    = (state_q != ST_IDLE);
    assign err     = err_q;
    assign err_idx = err_idx_q;

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// Scoreboard bench for sr_bank_ctrl with a behavioural flip-flop bank.
// Expectations follow SRBANK_VERIFY_EN the same way the design does.
module tb_sr_bank_ctrl;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int PC = 2;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [IW-1:0] a_idx = '0, b_idx = '0;
    logic          a_val = 1'b0, b_val = 1'b0;
    logic          a_ready, b_ready;
    logic [N-1:0]  S_n, R_n, Q;
    logic          busy, err;
    logic [IW-1:0] err_idx;
    logic          err_clr = 1'b0;

    always #5 clk = ~clk;

    sr_bank_ctrl dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_idx(a_idx), .a_val(a_val), .a_ready(a_ready),
        .b_valid(b_valid), .b_idx(b_idx), .b_val(b_val), .b_ready(b_ready),
        .S_n(S_n), .R_n(R_n), .Q(Q),
        .busy(busy), .err(err), .err_idx(err_idx), .err_clr(err_clr)
    );

    // Behavioural bank: a low S_n sets, a low R_n clears; stuck bits override.
    logic [N-1:0] ff = '0;
    logic [N-1:0] stuck_en = '0, stuck_val = '0;
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (!S_n[i]) ff[i] <= 1'b1;
            else if (!R_n[i]) ff[i] <= 1'b0;
    assign Q = (ff & ~stuck_en) | (stuck_val & stuck_en);

    typedef struct {
        bit who;
        int idx;
        bit val;
        int pulses;
        bit err;
        int err_idx;
        int gap;
    } txn_t;

    txn_t expq[$];
    int   checks = 0, errors = 0;
    bit   last_b = 1'b1;
    bit   err_m = 1'b0;
    int   err_idx_m = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int busy_cycles(input int pulses);
`ifdef SRBANK_VERIFY_EN
        return pulses * (PC + 2);
`else
        return PC + 1;
`endif
    endfunction

    function automatic txn_t model(input bit who, input int idx, input bit val);
        txn_t t;
        bit fail;
`ifdef SRBANK_VERIFY_EN
        fail = stuck_en[idx] && (stuck_val[idx] != val);
`else
        fail = 1'b0;
`endif
        t.who    = who;
        t.idx    = idx;
        t.val    = val;
        t.pulses = fail ? 1 + MR : 1;
        if (fail) begin
            err_m     = 1'b1;
            err_idx_m = idx;
        end
        t.err     = err_m;
        t.err_idx = err_idx_m;
        t.gap     = -1;
        return t;
    endfunction

    // Monitor: per-cycle line invariant plus per-transaction scoreboard.
    int   cycle_no = 0, last_gnt = 0, cyc = 0, low = 0;
    bit   cur_act = 1'b0;
    txn_t cur;
    always @(negedge clk) begin
        cycle_no++;
        if (mon_en) begin
            chk("lines_low_max1", ($countones(~S_n) + $countones(~R_n)) <= 1, 1);
            if (cur_act) begin
                if (busy) begin
                    cyc++;
                    if (cur.val ? !S_n[cur.idx] : !R_n[cur.idx]) low++;
                end else begin
                    chk("busy_cycles", cyc, busy_cycles(cur.pulses));
                    chk("pulse_cycles", low, cur.pulses * PC);
                    chk("err", err, cur.err);
                    if (cur.err) chk("err_idx", err_idx, cur.err_idx);
                    cur_act = 1'b0;
                end
            end
            if (a_ready || b_ready) begin
                chk("single_grant", a_ready & b_ready, 0);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_unexpected: a_ready=%0b b_ready=%0b", a_ready, b_ready);
                end else begin
                    cur = expq.pop_front();
                    chk("grant_is_b", b_ready, cur.who);
                    if (cur.gap >= 0) chk("grant_gap", cycle_no - last_gnt, cur.gap);
                    last_gnt = cycle_no;
                    cur_act  = 1'b1;
                    cyc      = 0;
                    low      = 0;
                end
            end
        end
    end

    // mode 0: A only, 1: B only, 2: both in the same cycle.
    task automatic round(input int mode, input int ia, input int ib,
                         input bit va, input bit vb, input bit hold_clr);
        bit   need_a = (mode != 1), need_b = (mode != 0);
        bit   ga, gb, done = 1'b0;
        txn_t t1, t2;
        if (mode == 2) begin
            if (last_b) begin
                t1 = model(1'b0, ia, va);
                t2 = model(1'b1, ib, vb);
            end else begin
                t1 = model(1'b1, ib, vb);
                t2 = model(1'b0, ia, va);
            end
            t2.gap = busy_cycles(t1.pulses) + 1;
            expq.push_back(t1);
            expq.push_back(t2);
            last_b = t2.who;
        end else begin
            t1 = model(mode == 1, mode == 1 ? ib : ia, mode == 1 ? vb : va);
            expq.push_back(t1);
            last_b = t1.who;
        end
        a_idx = IW'(ia); a_val = va; a_valid = need_a;
        b_idx = IW'(ib); b_val = vb; b_valid = need_b;
        err_clr = hold_clr;
        for (int k = 0; k < 200 && (need_a || need_b); k++) begin
            @(negedge clk);
            ga = a_ready;
            gb = b_ready;
            step();
            if (ga) begin a_valid = 1'b0; need_a = 1'b0; end
            if (gb) begin b_valid = 1'b0; need_b = 1'b0; end
        end
        if (need_a || need_b) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: pending a=%0b b=%0b", need_a, need_b);
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) begin done = 1'b1; break; end
        end
        err_clr = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0b", busy);
        end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_S_n", S_n, 8'hFF);
        chk("rst_R_n", R_n, 8'hFF);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_ready", {a_ready, b_ready}, 0);

        // Start a write, then reset in the middle of its pulse.
        step();
        a_idx = 3'd3; a_val = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        chk("first_a_ready", a_ready, 1);
        step();
        a_valid = 1'b0;
        @(negedge clk);
        chk("drive1_S_n", S_n, 8'hF7);
        chk("drive1_R_n", R_n, 8'hFF);
        chk("drive1_busy", busy, 1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("drive2_S_n", S_n, 8'hF7);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_S_n", S_n, 8'hFF);
        chk("midrst_R_n", R_n, 8'hFF);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err, 0);
        step();

        mon_en = 1'b1;
        last_b = 1'b1;
        err_m  = 1'b0;
        // First tie after reset must go to A.
        round(2, 0, 1, 1'b1, 1'b0, 1'b0);
        round(2, 4, 6, 1'b0, 1'b1, 1'b0);
        round(2, 7, 2, 1'b1, 1'b1, 1'b0);
        // Q tied low: a set still gets exactly one pulse without verify.
        stuck_en = '1; stuck_val = '0;
        round(0, 1, 0, 1'b1, 1'b0, 1'b0);
        stuck_en = 8'h20;
        round(0, 5, 0, 1'b1, 1'b0, 1'b0);
        // New failure coincides with err_clr; the failure must win.
        stuck_en = 8'h04;
        round(0, 2, 0, 1'b1, 1'b0, 1'b1);
        stuck_en = '0;

        repeat (150) begin
            if ($urandom_range(0, 3) == 0) begin
                stuck_en  = 8'($urandom) & 8'($urandom);
                stuck_val = 8'($urandom);
            end else begin
                stuck_en = '0;
            end
            if ($urandom_range(0, 5) == 0) begin
                err_clr = 1'b1;
                step();
                err_clr = 1'b0;
                err_m   = 1'b0;
                @(negedge clk);
                chk("err_cleared", err, 0);
                step();
            end
            round($urandom_range(0, 2), $urandom_range(0, N - 1),
                  $urandom_range(0, N - 1), 1'($urandom), 1'($urandom), 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end

        repeat (3) step();
        chk("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
